// File: rtl/resv_wb_bcast_pkg.sv
// rtl/resv_wb_bcast_pkg.sv - shared reservation-station widths and constants
package resv_wb_bcast_pkg;

  localparam int W_RX_A    = 5;
  localparam int W_RX_D    = 32;
  localparam int DEPTH_DEF = 4;

  // Idle broadcasts target r0, which every reservation cell treats as a no-op match.
  localparam logic [W_RX_A-1:0] IDLE_ADDR = '0;

  typedef enum logic {
    PIP0 = 1'b0,
    PIP1 = 1'b1
  } pip_e;

endpackage

// File: rtl/resv_wb_fifo.sv
// rtl/resv_wb_fifo.sv - per-pipe writeback result queue (address + data entries)
module resv_wb_fifo
  import resv_wb_bcast_pkg::*;
#(
  parameter int W_A   = W_RX_A,
  parameter int W_D   = W_RX_D,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           push,
  input  logic [W_A-1:0] push_a,
  input  logic [W_D-1:0] push_d,
  input  logic           pop,
  output logic [W_A-1:0] head_a,
  output logic [W_D-1:0] head_d,
  output logic           head_v,
  output logic [CW-1:0]  count
);

  logic [W_A+W_D-1:0] mem_q [DEPTH];
  logic [W_A+W_D-1:0] mem_d [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  // Pointers are exactly PW bits wide, so increment wraps modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {push_a, push_d};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign {head_a, head_d} = mem_q[rd_ptr_q];
  assign head_v           = (count_q != '0);
  assign count            = count_q;

endmodule

// File: rtl/resv_wb_bcast.sv
// rtl/resv_wb_bcast.sv - two-pipe writeback queues with round-robin register broadcast
module resv_wb_bcast
  import resv_wb_bcast_pkg::*;
#(
  parameter int W_rx_a = W_RX_A,
  parameter int W_rx_d = W_RX_D,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              i0_v,
  input  logic [W_rx_a-1:0] i0_rd_a,
  input  logic [W_rx_d-1:0] i0_rd_d,
  output logic              o0_rdy,
  input  logic              i1_v,
  input  logic [W_rx_a-1:0] i1_rd_a,
  input  logic [W_rx_d-1:0] i1_rd_d,
  output logic              o1_rdy,
  output logic [W_rx_a-1:0] addr_reg_upt,
  output logic [W_rx_d-1:0] data_reg_upt,
  output logic              upt_v
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [W_rx_a-1:0] IDLE_A = W_rx_a'(IDLE_ADDR);

  logic              push0, push1, pop0, pop1;
  logic [W_rx_a-1:0] head0_a, head1_a;
  logic [W_rx_d-1:0] head0_d, head1_d;
  logic              head0_v, head1_v;
  logic [CW-1:0]     count0, count1;

  pip_e              rr_q, rr_d;
  logic [W_rx_a-1:0] addr_q, addr_d;
  logic [W_rx_d-1:0] data_q, data_d;
  logic              upt_v_q, upt_v_d;

  // Ready looks only at registered occupancy; a full queue stays closed even on a pop cycle.
  assign o0_rdy = (count0 < CW'(DEPTH));
  assign o1_rdy = (count1 < CW'(DEPTH));

  // r0 results complete the handshake but carry nothing worth broadcasting.
  assign push0 = i0_v && o0_rdy && (i0_rd_a != IDLE_A);
  assign push1 = i1_v && o1_rdy && (i1_rd_a != IDLE_A);

  resv_wb_fifo #(.W_A(W_rx_a), .W_D(W_rx_d), .DEPTH(DEPTH)) u_q0 (
    .clk    (clk),
    .clear  (clear),
    .push   (push0),
    .push_a (i0_rd_a),
    .push_d (i0_rd_d),
    .pop    (pop0),
    .head_a (head0_a),
    .head_d (head0_d),
    .head_v (head0_v),
    .count  (count0)
  );

  resv_wb_fifo #(.W_A(W_rx_a), .W_D(W_rx_d), .DEPTH(DEPTH)) u_q1 (
    .clk    (clk),
    .clear  (clear),
    .push   (push1),
    .push_a (i1_rd_a),
    .push_d (i1_rd_d),
    .pop    (pop1),
    .head_a (head1_a),
    .head_d (head1_d),
    .head_v (head1_v),
    .count  (count1)
  );

  // After serving one pipe the pointer always favours the other one next.
  always_comb begin
    pop0    = head0_v && (!head1_v || (rr_q == PIP0));
    pop1    = head1_v && !pop0;
    rr_d    = rr_q;
    upt_v_d = 1'b0;
    addr_d  = IDLE_A;
    data_d  = '0;
    if (pop0) begin
      rr_d    = PIP1;
      upt_v_d = 1'b1;
      addr_d  = head0_a;
      data_d  = head0_d;
    end else if (pop1) begin
      rr_d    = PIP0;
      upt_v_d = 1'b1;
      addr_d  = head1_a;
      data_d  = head1_d;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rr_q    <= PIP0;
      upt_v_q <= 1'b0;
      addr_q  <= IDLE_A;
      data_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      upt_v_q <= upt_v_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign addr_reg_upt = addr_q;
  assign data_reg_upt = data_q;
  assign upt_v        = upt_v_q;

endmodule

// File: tb/tb_resv_wb_bcast.sv
// tb/tb_resv_wb_bcast.sv - directed vector table plus queue-model sequences for resv_wb_bcast
module tb_resv_wb_bcast;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          i0_v, i1_v;
  logic [AW-1:0] i0_rd_a, i1_rd_a;
  logic [DW-1:0] i0_rd_d, i1_rd_d;
  logic          o0_rdy, o1_rdy, upt_v;
  logic [AW-1:0] addr_reg_upt;
  logic [DW-1:0] data_reg_upt;

  always #5 clk = ~clk;

  resv_wb_bcast #(.W_rx_a(AW), .W_rx_d(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .clear        (clear),
    .i0_v         (i0_v),
    .i0_rd_a      (i0_rd_a),
    .i0_rd_d      (i0_rd_d),
    .o0_rdy       (o0_rdy),
    .i1_v         (i1_v),
    .i1_rd_a      (i1_rd_a),
    .i1_rd_d      (i1_rd_d),
    .o1_rdy       (o1_rdy),
    .addr_reg_upt (addr_reg_upt),
    .data_reg_upt (data_reg_upt),
    .upt_v        (upt_v)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    vec_t r;
    r.v0 = v0; r.a0 = a0; r.d0 = d0;
    r.v1 = v1; r.a1 = a1; r.d1 = d1;
    r.ev = ev; r.ea = ea; r.ed = ed;
    return r;
  endfunction

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq0[$];
  ent_t          mq1[$];
  logic          m_rr;
  logic          m_v;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_rr = 1'b0;
    m_v  = 1'b0;
    m_a  = '0;
    m_d  = '0;
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    i0_v = v0; i0_rd_a = a0; i0_rd_d = d0;
    i1_v = v1; i1_rd_a = a1; i1_rd_d = d1;
  endtask

  // One clock of stimulus starting at a falling edge; reference queues advance across the rising edge.
  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input string tag);
    logic hv0, hv1, r0, r1;
    ent_t e;
    drive(v0, a0, d0, v1, a1, d1);
    r0  = (mq0.size() < DEPTH);
    r1  = (mq1.size() < DEPTH);
    hv0 = (mq0.size() != 0);
    hv1 = (mq1.size() != 0);
    m_v = 1'b0; m_a = '0; m_d = '0;
    if (hv0 && (!hv1 || !m_rr)) begin
      e = mq0.pop_front(); m_v = 1'b1; m_a = e.a; m_d = e.d; m_rr = 1'b1;
    end else if (hv1) begin
      e = mq1.pop_front(); m_v = 1'b1; m_a = e.a; m_d = e.d; m_rr = 1'b0;
    end
    if (v0 && r0 && (a0 != '0)) mq0.push_back({a0, d0});
    if (v1 && r1 && (a1 != '0)) mq1.push_back({a1, d1});
    @(posedge clk);
    @(negedge clk);
    chk({tag, " upt_v"}, upt_v, m_v);
    chk({tag, " addr"}, addr_reg_upt, m_a);
    chk({tag, " data"}, data_reg_upt, m_d);
    chk({tag, " o0_rdy"}, o0_rdy, (mq0.size() < DEPTH));
    chk({tag, " o1_rdy"}, o1_rdy, (mq1.size() < DEPTH));
  endtask

  task automatic pulse_reset();
    clear = 1'b1;
    drive(0, '0, '0, 0, '0, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  vec_t vecs[14];
  logic saw_full1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    drive(0, '0, '0, 0, '0, '0);
    model_reset();
    clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset upt_v", upt_v, 0);
    chk("reset addr", addr_reg_upt, 0);
    chk("reset data", data_reg_upt, 0);
    chk("reset o0_rdy", o0_rdy, 1);
    chk("reset o1_rdy", o1_rdy, 1);
    clear = 1'b0;

    // Row 0 lands on the first edge after release; rr starts at pip0.
    vecs[0]  = mk(1, 5'd3, 32'h11, 1, 5'd7, 32'h22, 0, 5'd0, 32'h0);
    vecs[1]  = mk(1, 5'd4, 32'h33, 1, 5'd8, 32'h44, 1, 5'd3, 32'h11);
    vecs[2]  = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h22);
    vecs[3]  = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd4, 32'h33);
    vecs[4]  = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd8, 32'h44);
    vecs[5]  = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    vecs[6]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    vecs[7]  = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF);
    vecs[8]  = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    vecs[9]  = mk(1, 5'd0, 32'h55, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    vecs[10] = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    vecs[11] = mk(0, 5'd0, 32'h0, 1, 5'd31, 32'hCAFEF00D, 0, 5'd0, 32'h0);
    vecs[12] = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd31, 32'hCAFEF00D);
    vecs[13] = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d upt_v", i), upt_v, vecs[i].ev);
      chk($sformatf("vec%0d addr", i), addr_reg_upt, vecs[i].ea);
      chk($sformatf("vec%0d data", i), data_reg_upt, vecs[i].ed);
      chk($sformatf("vec%0d o0_rdy", i), o0_rdy, 1);
      chk($sformatf("vec%0d o1_rdy", i), o1_rdy, 1);
    end
    drive(0, '0, '0, 0, '0, '0);

    // Both pipes push every cycle; alternating grants fill the queues until ready drops.
    pulse_reset();
    saw_full1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1, AW'(i + 1), 32'h1000 + i, 1, AW'(i + 11), 32'h2000 + i, $sformatf("full%0d", i));
      if (!o1_rdy) saw_full1 = 1'b1;
    end
    for (int i = 0; i < 12; i++) step(0, '0, '0, 0, '0, '0, $sformatf("drain%0d", i));
    chk("full o1_rdy seen low", saw_full1, 1);

    // Sustained traffic: a broadcast on every cycle once the first entry lands.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, AW'((i % 31) + 1), 32'hA000 + i, 1, AW'(((i + 7) % 31) + 1), 32'hB000 + i,
           $sformatf("tput%0d", i));
      if (i > 0) chk($sformatf("tput%0d every-cycle upt_v", i), upt_v, 1);
    end
    for (int i = 0; i < 12; i++) step(0, '0, '0, 0, '0, '0, $sformatf("tdrain%0d", i));

    // Clear asserted between edges must blank outputs at once and drop queued work.
    pulse_reset();
    for (int i = 0; i < 3; i++)
      step(1, AW'(9 + i), 32'hC000 + i, 1, AW'(20 + i), 32'hD000 + i, $sformatf("pre%0d", i));
    #2;
    clear = 1'b1;
    drive(0, '0, '0, 0, '0, '0);
    #1;
    chk("midclr upt_v", upt_v, 0);
    chk("midclr addr", addr_reg_upt, 0);
    chk("midclr data", data_reg_upt, 0);
    chk("midclr o0_rdy", o0_rdy, 1);
    chk("midclr o1_rdy", o1_rdy, 1);
    model_reset();
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 6; i++) step(0, '0, '0, 0, '0, '0, $sformatf("post%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
